// File: rtl/dc_reject_filter.sv
// Single-pole DC-blocking high-pass filter: y[n] = x[n] - x[n-1] + alpha*y[n-1].
// Feedback state keeps FRAC fractional bits; the output is rounded half-up and saturated to DW bits.
module dc_reject_filter #(
  parameter int DW   = 16,
  parameter int AW   = 24,
  parameter int FRAC = 24
) (
  input  logic                 aclk,
  input  logic                 reset,
  input  logic [AW-1:0]        alpha,
  input  logic signed [DW-1:0] in,
  input  logic                 in_valid,
  output logic signed [DW-1:0] out,
  output logic                 out_valid
);

  localparam int YW = DW + 2 + FRAC;
  localparam int PW = YW + AW + 1;
  localparam int QW = YW + 1 - FRAC;
  localparam logic [AW-1:0]        AMAX = AW'((2 ** (AW - 1)) - 1);
  localparam logic [YW:0]          HALF = {{(YW - FRAC + 1){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
  localparam logic signed [QW-1:0] QMAX = QW'((2 ** (DW - 1)) - 1);
  localparam logic signed [QW-1:0] QMIN = QW'(-(2 ** (DW - 1)));

  logic                 first_q, first_d;
  logic signed [DW-1:0] xPrev_q, xPrev_d;
  logic signed [YW-1:0] y_q, y_d;
  logic signed [DW-1:0] out_q, out_d;
  logic                 valid_q, valid_d;

  logic [AW-1:0]        aEff;
  logic signed [DW:0]   diff;
  logic signed [PW-1:0] prod;
  logic signed [YW-1:0] yNew;
  logic [YW:0]          yRnd;
  logic signed [QW-1:0] qVal;
  logic signed [DW-1:0] satOut;
  logic                 unusedBits;

  // Alpha at or above 1.0 is clamped just below it so the pole stays inside the unit circle.
  always_comb begin
    aEff   = (alpha > AMAX) ? AMAX : alpha;
    diff   = {in[DW-1], in} - {xPrev_q[DW-1], xPrev_q};
    prod   = PW'(y_q) * PW'($signed({1'b0, aEff}));
    yNew   = prod[YW+AW-2:AW-1] + {{(YW - DW - 1 - FRAC){diff[DW]}}, diff, {FRAC{1'b0}}};
    yRnd   = {yNew[YW-1], yNew} + HALF;
    qVal   = $signed(yRnd[YW:FRAC]);
    satOut = qVal[DW-1:0];
    if (qVal > QMAX) begin
      satOut = QMAX[DW-1:0];
    end else if (qVal < QMIN) begin
      satOut = QMIN[DW-1:0];
    end
  end

  assign unusedBits = ^{prod[PW-1:YW+AW-1], prod[AW-2:0], yRnd[FRAC-1:0]};

  always_comb begin
    first_d = first_q;
    xPrev_d = xPrev_q;
    y_d     = y_q;
    out_d   = out_q;
    valid_d = 1'b0;
    if (in_valid) begin
      valid_d = 1'b1;
      xPrev_d = in;
      first_d = 1'b0;
      // The first sample only primes x_prev, so a start-up offset never produces a step.
      if (first_q) begin
        y_d   = '0;
        out_d = '0;
      end else begin
        y_d   = yNew;
        out_d = satOut;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      first_q <= 1'b1;
      xPrev_q <= '0;
      y_q     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      first_q <= first_d;
      xPrev_q <= xPrev_d;
      y_q     <= y_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_dc_reject_filter.sv
// Self-checking bench for dc_reject_filter: directed scenarios plus randomized traffic,
// compared against a wide-integer arithmetic model of the filter equation.
module tb_dc_reject_filter;

  localparam int DW = 16;
  localparam int AW = 24;
  localparam longint ONE = 64'd8388608;

  logic                 aclk = 1'b0;
  logic                 reset = 1'b1;
  logic [AW-1:0]        alpha = '0;
  logic signed [DW-1:0] in = '0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] out;
  logic                 out_valid;

  int vectors = 0;
  int miscompares = 0;

  // Model state: plain integers, with a 128-bit feedback value that never wraps.
  bit                   mFirst = 1'b1;
  int                   mXprev = 0;
  logic signed [127:0]  mY = '0;
  logic signed [DW-1:0] mOut = '0;
  bit                   mValid = 1'b0;

  always #5 aclk = ~aclk;

  dc_reject_filter #(.DW(DW), .AW(AW), .FRAC(24)) dut (
    .aclk      (aclk),
    .reset     (reset),
    .alpha     (alpha),
    .in        (in),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
  );

  function automatic void modelStep(input bit rst, input bit v, input int x, input longint alph);
    logic signed [127:0] d128, a128, yn, r;
    longint aE;
    if (rst) begin
      mFirst = 1'b1; mXprev = 0; mY = '0; mOut = '0; mValid = 1'b0;
    end else if (!v) begin
      mValid = 1'b0;
    end else if (mFirst) begin
      mFirst = 1'b0; mXprev = x; mY = '0; mOut = '0; mValid = 1'b1;
    end else begin
      aE   = (alph >= ONE) ? ONE - 1 : alph;
      a128 = 128'(aE);
      d128 = 128'(x - mXprev);
      yn   = (d128 * 128'sd16777216) + ((mY * a128) >>> 23);
      mY   = yn;
      mXprev = x;
      r = (yn + 128'sd8388608) >>> 24;
      if (r > 128'sd32767) mOut = 16'sd32767;
      else if (r < -128'sd32768) mOut = -16'sd32768;
      else mOut = 16'(r);
      mValid = 1'b1;
    end
  endfunction

  task automatic applyStimulus(input bit rst, input bit v, input int x, input longint alph);
    @(negedge aclk);
    reset    = rst;
    in_valid = v;
    in       = 16'(x);
    alpha    = 24'(alph);
    @(posedge aclk);
    #1;
    modelStep(rst, v, x, alph);
  endtask

  task automatic checkOutput(input string tag);
    vectors++;
    assert (out === mOut && out_valid === mValid) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed out=%0d valid=%0b, expected out=%0d valid=%0b",
             tag, out, out_valid, mOut, mValid);
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    longint aNear;
    int     sgn;
    aNear = ONE - 1000;

    // Reset held with in_valid asserted: reset must win.
    applyStimulus(1, 1, 1234, 0); checkOutput("reset_a");
    applyStimulus(1, 1, -999, 0); checkOutput("reset_b");
    checkValue("reset_valid", int'(out_valid), 0);
    applyStimulus(0, 1, 500, 0);  checkOutput("first_sample");
    checkValue("first_out", int'(out), 0);
    checkValue("first_valid", int'(out_valid), 1);
    applyStimulus(0, 0, 777, 0);  checkOutput("idle_hold");
    checkValue("idle_valid", int'(out_valid), 0);

    // Exact DC from the first sample must give exactly zero.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 1, 16000, aNear);
      checkOutput("dc_model");
      checkValue("dc_zero", int'(out), 0);
    end

    // Step response and long decay.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, aNear);     checkOutput("step_first");
    applyStimulus(0, 1, 10000, aNear); checkOutput("step_edge");
    checkValue("step_10000", int'(out), 10000);
    applyStimulus(0, 1, 10000, aNear); checkOutput("step_next");
    checkValue("step_9999", int'(out), 9999);
    for (int i = 0; i < 8388; i++) begin
      applyStimulus(0, 1, 10000, aNear);
      if (i % 64 == 0) checkOutput("decay");
    end
    checkOutput("decay_end");
    vectors++;
    assert (int'(out) >= 3660 && int'(out) <= 3700) else begin
      miscompares++;
      $error("[TB] FAIL decay_level: observed %0d, expected about 3679", out);
    end

    // alpha=0 is a pure first difference, including saturation.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 100, 0);  checkValue("diff_first", int'(out), 0);
    applyStimulus(0, 1, 100, 0);  checkValue("diff_0", int'(out), 0);
    applyStimulus(0, 1, 300, 0);  checkValue("diff_200", int'(out), 200);
    applyStimulus(0, 1, -200, 0); checkValue("diff_m500", int'(out), -500);
    applyStimulus(0, 1, 32767, 0);  checkValue("diff_satpos", int'(out), 32767);
    applyStimulus(0, 1, -32768, 0); checkValue("diff_satneg", int'(out), -32768);
    checkOutput("diff_model");

    // Full-scale alternation near unity alpha, then an over-range alpha that must clamp.
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      sgn = (i % 2 == 0) ? 32767 : -32768;
      applyStimulus(0, 1, sgn, (i < 20) ? ONE - 1 : 64'hFFFFFF);
      checkOutput("alternate");
    end

    // Randomized traffic with gaps, alpha changes and occasional mid-stream resets.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(($urandom_range(99) == 0), ($urandom_range(9) < 8),
                    $signed(16'($urandom)), longint'($urandom_range(16777215)));
      checkOutput("random");
    end

    // Mid-stream reset restarts the first-sample handling.
    applyStimulus(0, 1, 12345, aNear);
    applyStimulus(1, 1, 5000, aNear); checkOutput("mid_reset");
    checkValue("mid_reset_out", int'(out), 0);
    applyStimulus(0, 1, -7000, aNear); checkOutput("mid_first");
    checkValue("mid_first_out", int'(out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
